// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one N-bit adder between the PC-increment
// path (requester 0) and the ALU add path (requester 1).

// Unsigned adder; overflow is the carry out of the top bit.
module full_adder #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b};

endmodule

module adder_arbiter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp0_valid,
  output logic [N-1:0] rsp0_sum,
  output logic         rsp0_overflow,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp1_sum,
  output logic         rsp1_overflow,
  input  logic         rsp1_ready,
  output logic [1:0]   grant
);

  logic [1:0]   rsp_valid_q, rsp_valid_d;
  logic [N-1:0] rsp0_sum_q, rsp0_sum_d;
  logic [N-1:0] rsp1_sum_q, rsp1_sum_d;
  logic [1:0]   rsp_ovf_q, rsp_ovf_d;
  logic         last_grant_q, last_grant_d;

  logic [1:0]   can_take;
  logic [1:0]   elig;
  logic [1:0]   grant_c;
  logic [N-1:0] op_a, op_b, add_sum;
  logic         add_ovf;

  // Eligibility and one-hot round-robin grant; nothing granted in reset.
  always_comb begin
    can_take = ~rsp_valid_q | {rsp1_ready, rsp0_ready};
    elig     = {req1_valid, req0_valid} & can_take;
    grant_c  = 2'b00;
    if (rst_n) begin
      unique case (1'b1)
        (elig == 2'b11): grant_c = last_grant_q ? 2'b01 : 2'b10;
        (elig == 2'b01): grant_c = 2'b01;
        (elig == 2'b10): grant_c = 2'b10;
        default:         grant_c = 2'b00;
      endcase
    end
  end

  assign grant      = grant_c;
  assign req0_ready = grant_c[0];
  assign req1_ready = grant_c[1];

  // Operand mux in front of the single shared adder.
  always_comb begin
    op_a = grant_c[1] ? req1_a : req0_a;
    op_b = grant_c[1] ? req1_b : req0_b;
  end

  full_adder #(.N(N)) u_add (
    .a        (op_a),
    .b        (op_b),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  // Next state: slots load on grant, drain on ready, else hold.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_c != 2'b00) last_grant_d = grant_c[1];

    rsp_valid_d = grant_c |
                  (rsp_valid_q & ~{rsp1_ready, rsp0_ready});

    rsp0_sum_d = rsp0_sum_q;
    rsp1_sum_d = rsp1_sum_q;
    rsp_ovf_d  = rsp_ovf_q;
    if (grant_c[0]) begin
      rsp0_sum_d   = add_sum;
      rsp_ovf_d[0] = add_ovf;
    end
    if (grant_c[1]) begin
      rsp1_sum_d   = add_sum;
      rsp_ovf_d[1] = add_ovf;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q  <= 2'b00;
      rsp0_sum_q   <= '0;
      rsp1_sum_q   <= '0;
      rsp_ovf_q    <= 2'b00;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp0_sum_q   <= rsp0_sum_d;
      rsp1_sum_q   <= rsp1_sum_d;
      rsp_ovf_q    <= rsp_ovf_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp0_valid    = rsp_valid_q[0];
  assign rsp1_valid    = rsp_valid_q[1];
  assign rsp0_sum      = rsp0_sum_q;
  assign rsp1_sum      = rsp1_sum_q;
  assign rsp0_overflow = rsp_ovf_q[0];
  assign rsp1_overflow = rsp_ovf_q[1];

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: vector table, scoreboard and
// hand-written backpressure / reset sequences.
module tb_adder_arbiter;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp0_valid, rsp1_valid;
  logic [N-1:0] rsp0_sum, rsp1_sum;
  logic         rsp0_overflow, rsp1_overflow;
  logic         rsp0_ready, rsp1_ready;
  logic [1:0]   grant;

  int checks = 0;
  int errors = 0;

  logic [N:0] q0[$];
  logic [N:0] q1[$];
  bit         lg = 1'b1;

  always #5 clk = ~clk;

  adder_arbiter #(.N(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_valid    (req0_valid),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .req1_ready    (req1_ready),
    .rsp0_valid    (rsp0_valid),
    .rsp0_sum      (rsp0_sum),
    .rsp0_overflow (rsp0_overflow),
    .rsp0_ready    (rsp0_ready),
    .rsp1_valid    (rsp1_valid),
    .rsp1_sum      (rsp1_sum),
    .rsp1_overflow (rsp1_overflow),
    .rsp1_ready    (rsp1_ready),
    .grant         (grant)
  );

  task automatic chk(input bit ok, input string name,
                     input logic [N:0] act,
                     input logic [N:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Scoreboard and arbitration model, sampled on the falling edge.
  always @(negedge clk) begin
    logic       e0, e1;
    logic [1:0] eg;
    logic [N:0] exp;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      lg = 1'b1;
      chk(grant == 2'b00 && !req0_ready && !req1_ready,
          "rst_grant", {63'd0, req1_ready, req0_ready, grant},
          '0);
    end else begin
      e0 = req0_valid && (!rsp0_valid || rsp0_ready);
      e1 = req1_valid && (!rsp1_valid || rsp1_ready);
      if (e0 && e1) eg = lg ? 2'b01 : 2'b10;
      else          eg = {e1, e0};
      chk(grant == eg, "grant", {63'd0, grant}, {63'd0, eg});
      chk({req1_ready, req0_ready} == grant, "ready",
          {63'd0, req1_ready, req0_ready}, {63'd0, grant});
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) begin
          chk(1'b0, "sb0_empty", {rsp0_overflow, rsp0_sum}, '0);
        end else begin
          exp = q0.pop_front();
          chk({rsp0_overflow, rsp0_sum} == exp, "sb0",
              {rsp0_overflow, rsp0_sum}, exp);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) begin
          chk(1'b0, "sb1_empty", {rsp1_overflow, rsp1_sum}, '0);
        end else begin
          exp = q1.pop_front();
          chk({rsp1_overflow, rsp1_sum} == exp, "sb1",
              {rsp1_overflow, rsp1_sum}, exp);
        end
      end
      if (req0_valid && req0_ready)
        q0.push_back({1'b0, req0_a} + {1'b0, req0_b});
      if (req1_valid && req1_ready)
        q1.push_back({1'b0, req1_a} + {1'b0, req1_b});
      if (eg != 2'b00) lg = eg[1];
    end
  end

  typedef struct {
    bit           sel;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] sum;
    bit           ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic drive(input bit sel, input bit v,
                       input logic [N-1:0] a,
                       input logic [N-1:0] b);
    if (sel) begin
      req1_valid = v; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b;
    end
  endtask

  // Apply one vector alone, wait for its grant, check the response.
  task automatic run_vec(input vec_t v);
    int n = 0;
    bit rdy;
    @(posedge clk); #1;
    drive(v.sel, 1'b1, v.a, v.b);
    forever begin
      @(negedge clk);
      rdy = v.sel ? req1_ready : req0_ready;
      if (rdy) break;
      n++;
      if (n > 10) begin
        chk(1'b0, "vec_timeout", '0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    drive(v.sel, 1'b0, v.a, v.b);
    @(negedge clk);
    if (v.sel)
      chk(rsp1_valid && rsp1_sum == v.sum && rsp1_overflow == v.ovf,
          "vec1", {rsp1_overflow, rsp1_sum}, {v.ovf, v.sum});
    else
      chk(rsp0_valid && rsp0_sum == v.sum && rsp0_overflow == v.ovf,
          "vec0", {rsp0_overflow, rsp0_sum}, {v.ovf, v.sum});
  endtask

  initial begin
    logic [1:0]   pg;
    logic [N-1:0] held;
    int           n;

    vecs[0] = '{1'b0, 64'd2, 64'd5, 64'd7, 1'b0};
    vecs[1] = '{1'b1, 64'd0, 64'hffff, 64'hffff, 1'b0};
    vecs[2] = '{1'b0, 64'hf43a_a301, 64'hb9c2_d427,
                64'h1_adfd_7728, 1'b0};
    vecs[3] = '{1'b1, 64'h7fff_ffff_ffff_ffff,
                64'h8fff_ffff_ffff_0000,
                64'h0fff_ffff_fffe_ffff, 1'b1};
    vecs[4] = '{1'b1, '1, '1, 64'hffff_ffff_ffff_fffe, 1'b1};
    vecs[5] = '{1'b0, '1, 64'd1, 64'd0, 1'b1};

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 64'd3; req0_b = 64'd4;
    req1_valid = 1'b1; req1_a = 64'd1; req1_b = 64'd1;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk(!rsp0_valid && !rsp1_valid, "rst_valid",
        {63'd0, rsp1_valid, rsp0_valid}, '0);
    chk(rsp0_sum == 0 && !rsp0_overflow, "rst_sum0",
        {rsp0_overflow, rsp0_sum}, '0);
    chk(rsp1_sum == 0 && !rsp1_overflow, "rst_sum1",
        {rsp1_overflow, rsp1_sum}, '0);

    // Single request, response held until consumed.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 64'd2, 64'd5);
    @(negedge clk);
    chk(grant == 2'b01 && req0_ready, "single_grant",
        {63'd0, grant}, 65'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk(rsp0_valid && rsp0_sum == 7 && !rsp0_overflow,
        "single_rsp", {rsp0_overflow, rsp0_sum}, 65'd7);
    @(posedge clk); #1;
    @(negedge clk);
    chk(rsp0_valid && rsp0_sum == 7, "single_hold",
        {64'd0, rsp0_valid}, 65'd1);
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk(!rsp0_valid, "single_clear", {64'd0, rsp0_valid}, '0);
    rsp1_ready = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Contention: grants alternate every cycle.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 64'hf43a_a301, 64'hb9c2_d427);
    drive(1'b1, 1'b1, 64'd0, 64'hffff);
    @(negedge clk);
    pg = grant;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk(grant != pg && grant != 2'b00, "rr_alt",
          {63'd0, grant}, {63'd0, ~pg});
      pg = grant;
    end
    chk(rsp0_sum == 64'h1_adfd_7728 && !rsp0_overflow, "rr_sum0",
        {rsp0_overflow, rsp0_sum}, {1'b0, 64'h1_adfd_7728});
    chk(rsp1_sum == 64'hffff && !rsp1_overflow, "rr_sum1",
        {rsp1_overflow, rsp1_sum}, 65'hffff);

    // Backpressure on slot 0 must not stall requester 1.
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    drive(1'b0, 1'b1, 64'd100, 64'd23);
    n = 0;
    while (!(rsp0_valid && rsp0_sum == 64'd123) && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk(n < 10, "bp_fill", n, 10);
    held = rsp0_sum;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk(grant == 2'b10 && !req0_ready, "bp_grant",
          {63'd0, grant}, 65'd2);
      chk(rsp0_valid && rsp0_sum == held, "bp_hold",
          {rsp0_overflow, rsp0_sum}, {1'b0, held});
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk(grant == 2'b01 && req0_ready, "bp_release",
        {63'd0, grant}, 65'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    chk(rsp0_valid && rsp0_sum == 64'd123, "bp_reload",
        {64'd0, rsp0_valid}, 65'd1);
    repeat (2) @(posedge clk);
    #1;

    // Reset while a fresh result sits in slot 0.
    rsp0_ready = 1'b0;
    drive(1'b0, 1'b1, 64'd1, 64'd1);
    @(negedge clk);
    chk(req0_ready, "mid_accept", {64'd0, req0_ready}, 65'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 64'd5, 64'd6);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    drive(1'b1, 1'b0, 64'd0, 64'd0);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk(!rsp0_valid && rsp0_sum == 0 && !rsp0_overflow, "mid_rst",
        {rsp0_valid, rsp0_sum}, '0);
    chk(!rsp1_valid, "mid_rst1", {64'd0, rsp1_valid}, '0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 64'd8, 64'd9);
    drive(1'b1, 1'b1, 64'd10, 64'd11);
    @(negedge clk);
    chk(grant == 2'b01, "mid_first", {63'd0, grant}, 65'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(q0.size() == 0 && q1.size() == 0, "sb_drain",
        q0.size() + q1.size(), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 64-bit `full_adder` instance between two requesters: requester 0 is the PC-increment path, requester 1 is the ALU add path.
- Requests use a valid/ready handshake. Grants are round-robin, one addition per cycle.
- Each requester has a one-entry registered response slot with its own valid/ready handshake.
- Sits between issue logic and the shared adder in the RISC-V datapath.

Parameters:
- N, 64, operand and sum width; passed to the internal `full_adder`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- req0_valid  input  1  requester 0 presents operands.
- req0_a  input  N  requester 0 first operand.
- req0_b  input  N  requester 0 second operand.
- req0_ready  output  1  requester 0 operands accepted this cycle when high together with req0_valid.
- req1_valid, req1_a, req1_b, req1_ready  same as requester 0, for requester 1.
- rsp0_valid  output  1  response slot 0 holds a result.
- rsp0_sum  output  N  registered sum for requester 0.
- rsp0_overflow  output  1  registered overflow for requester 0.
- rsp0_ready  input  1  requester 0 consumes the response.
- rsp1_valid, rsp1_sum, rsp1_overflow, rsp1_ready  same as slot 0, for requester 1.
- grant  output  2  one-hot: bit i = requester i wins the adder this cycle; 2'b00 when no grant.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is synchronous and active-low.
- Reset values (rst_n low at a clock edge):
  - rsp0_valid = rsp1_valid = 0.
  - rsp*_sum = 0, rsp*_overflow = 0.
  - last_grant = 1, so requester 0 wins the first contention.
  - While rst_n is low: req*_ready = 0 and grant = 0.
- Reset mid-operation discards held results and any same-cycle acceptance; no response appears after reset deasserts.
- Eligibility: requester i is eligible when req_i_valid = 1 and slot i can take a result. Slot i can take a result when rsp_i_valid = 0, or when rsp_i_valid = 1 and rsp_i_ready = 1 in the same cycle (pass-through, full throughput).
- Arbitration, combinational, one grant per cycle:
  - Only one requester eligible: that requester is granted.
  - Both eligible: the requester not equal to last_grant is granted.
  - last_grant updates only on a cycle with a grant; it holds otherwise.
- req_i_ready = grant[i]. A handshake (valid and ready both high) is the acceptance; a requester not granted must hold its operands stable until accepted.
- Datapath:
  - The granted requester's a/b drive the single `full_adder` through a 2:1 mux.
  - On acceptance, slot i registers the `full_adder` sum and overflow and sets rsp_i_valid = 1.
  - Latency: operands accepted at edge t produce rsp_i_valid high from edge t+1.
- Overflow: the `full_adder` overflow output, i.e. unsigned carry out of bit N-1. Sum wraps modulo 2^N.
- Response hold: rsp_i_valid, sum and overflow stay constant while rsp_i_ready = 0.
  - rsp_i_ready high with no new acceptance: rsp_i_valid clears next edge.
  - rsp_i_ready high with a simultaneous acceptance: the slot reloads with the new result and rsp_i_valid stays 1.
- Backpressure isolation: a full, stalled slot i blocks only requester i. The other requester is granted every cycle it is eligible.
- rsp_i_ready while rsp_i_valid = 0 has no effect.
- Invariant: grant is never 2'b11.

Test Plan:
- Reset then single request: hold rst_n low 2 cycles, then req0 a=2, b=5. Expect grant=01 and req0_ready=1 in that cycle. Next cycle rsp0_valid=1, rsp0_sum=7, rsp0_overflow=0. rsp0_ready=1 clears rsp0_valid the following cycle.
- Contention and round-robin: both requests valid continuously, both rsp_ready=1. Requester 0 operands a=0x0000_0000_f43a_a301, b=0x0000_0000_b9c2_d427; requester 1 operands a=0, b=0xffff.
  - Expect grants 01, 10, 01, 10, alternating every cycle.
  - rsp0_sum = 0x0000_0001_adfd_7728, rsp1_sum = 0xffff, both overflow=0.
- Overflow and wrap: req1 a=0x7fff_ffff_ffff_ffff, b=0x8fff_ffff_ffff_0000 gives rsp1_sum=0x0fff_ffff_fffe_ffff, overflow=1. Then a=b=0xffff_ffff_ffff_ffff gives sum=0xffff_ffff_ffff_fffe, overflow=1.
- Backpressure isolation: rsp0_ready=0 with slot 0 full, both requests valid.
  - Expect req0_ready=0 and grant=10 every cycle; rsp0 values stay stable.
  - Raise rsp0_ready: req0 is granted in that same cycle and slot 0 reloads with no bubble.
- Reset mid-operation: accept req0 (a=1, b=1), then assert rst_n low in the same cycle rsp0_valid would rise. Expect rsp0_valid=0 and sum=0 after reset. First contention after reset grants requester 0.
